run_pattern_gen: RTL and testbench

Serial pattern transmitter that pairs with the team's run-of-four sequence detector, which looks for four or more equal consecutive bits.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per cycle on a free-running serial line.
- Carries an internal golden model of the detector, so expect_hit predicts the detector's output cycle-for-cycle. A bench can compare the two directly.

---
 rtl/run_pkg.sv | 16 +
 rtl/run_tracker.sv | 34 +++
 rtl/run_pattern_gen.sv | 85 ++++++++
 tb/tb_run_pattern_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/run_pkg.sv
// Shared types and helpers for the run-pattern transmitter and its detector model.
package run_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int RUN_DEFAULT = 4;

  // A requested length of zero, or one longer than the word, means "the whole word".
  function automatic int clamp_len(input int len, input int w);
    return (len == 0 || len > w) ? w : len;
  endfunction

endpackage

// File: rtl/run_tracker.sv
// Golden model of the run-of-RUN detector: saturating run count plus previous bit.
module run_tracker #(
  parameter int RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  output logic hit
);

  localparam int CW = $clog2(RUN + 1);
  localparam logic [CW-1:0] RUN_C = CW'(RUN);

  logic [CW-1:0] count;
  logic          prev_bit;

  // A zero count marks "no previous bit yet", so the first sample always starts a run of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      prev_bit <= 1'b0;
    end else begin
      if (count != '0 && bit_in == prev_bit) begin
        if (count != RUN_C) count <= count + 1'b1;
      end else begin
        count <= CW'(1);
      end
      prev_bit <= bit_in;
    end
  end

  assign hit = (count == RUN_C);

endmodule

// File: rtl/run_pattern_gen.sv
// Serial word transmitter with a built-in prediction of the run detector's output.
module run_pattern_gen
  import run_pkg::*;
#(
  parameter int   W        = 8,
  parameter int   LEN_W    = 4,
  parameter int   RUN      = RUN_DEFAULT,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             expect_hit,
  output logic             busy
);

  state_t           state, next_state;
  logic [W-1:0]     shift_reg;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] eff_len;
  logic             last_bit;
  logic             accept;

  assign eff_len  = LEN_W'(clamp_len(32'(in_len), W));
  assign last_bit = (bit_cnt == LEN_W'(1));

  // Ready on the last bit lets the next word follow with no idle gap.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: in_ready = reset;
      SEND: in_ready = reset & last_bit;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      next_state = SEND;
    end else if (state == SEND && last_bit) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= in_data;
      bit_cnt   <= eff_len;
    end else if (state == SEND) begin
      shift_reg <= {1'b0, shift_reg[W-1:1]};
      bit_cnt   <= bit_cnt - 1'b1;
    end
  end

  assign serial_valid = (state == SEND);
  assign busy         = (state == SEND);
  assign serial_out   = (state == SEND) ? shift_reg[0] : IDLE_BIT;

  // The tracker watches the line continuously, idle fill included, like the real detector.
  run_tracker #(
    .RUN(RUN)
  ) u_tracker (
    .clk   (clk),
    .reset (reset),
    .bit_in(serial_out),
    .hit   (expect_hit)
  );

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen: serial stream, handshake and predicted detector output.
module tb_run_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic [3:0] inLen;
  logic       serialOut;
  logic       serialValid;
  logic       expectHit;
  logic       busy;

  int vectors;
  int miscompares;

  run_pattern_gen #(
    .W(8), .LEN_W(4), .RUN(4), .IDLE_BIT(1'b0)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_data     (inData),
    .in_len      (inLen),
    .serial_out  (serialOut),
    .serial_valid(serialValid),
    .expect_hit  (expectHit),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are checked at the falling edge; inputs change there too.
  task automatic checkOutput(input string tag, input logic so, input logic sv,
                             input logic hit, input logic rdy, input logic bsy);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {serialOut, serialValid, expectHit, inReady, busy};
    exp = {so, sv, hit, rdy, bsy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got out/valid/hit/ready/busy=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] l);
    inValid = v;
    inData  = d;
    inLen   = l;
    @(negedge clk);
  endtask

  // Called on the cycle showing bit 0; the inputs given are what is offered at the last bit.
  task automatic checkWord(input string tag, input logic [7:0] d, input int n,
                           input logic [7:0] hitExp, input logic nextValid,
                           input logic [7:0] nextData, input logic [3:0] nextLen);
    inValid = nextValid;
    inData  = nextData;
    inLen   = nextLen;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), d[i], 1'b1, hitExp[i], (i == n - 1), 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    inValid     = 1'b0;
    inData      = 8'h00;
    inLen       = 4'd0;

    @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d", k), 1'b0, 1'b0, (k >= 4), 1'b1, 1'b0);
    end

    $display("[TB] word 0x0F, len 8");
    applyStimulus(1'b1, 8'h0F, 4'd8);
    checkWord("w0F", 8'h0F, 8, 8'h11, 1'b0, 8'h00, 4'd0);
    checkOutput("w0F_idle0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w0F_idle1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] word 0x55, alternating");
    applyStimulus(1'b1, 8'h55, 4'd8);
    checkWord("w55", 8'h55, 8, 8'h01, 1'b0, 8'h00, 4'd0);
    checkOutput("w55_idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w55_idle1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w55_idle2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w55_idle3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] back-to-back 0xAA then 0x0F");
    applyStimulus(1'b1, 8'hAA, 4'd8);
    checkWord("bbAA", 8'hAA, 8, 8'h03, 1'b1, 8'h0F, 4'd8);
    checkWord("bb0F", 8'h0F, 8, 8'h18, 1'b0, 8'h00, 4'd0);
    checkOutput("bb_idle0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] length edge cases");
    applyStimulus(1'b1, 8'h07, 4'd3);
    checkWord("len3", 8'h07, 3, 8'h01, 1'b0, 8'h00, 4'd0);
    checkOutput("len3_idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("len3_idle1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h80, 4'd0);
    checkWord("len0", 8'h80, 8, 8'hFC, 1'b0, 8'h00, 4'd0);
    checkOutput("len0_idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 8'h01, 4'd15);
    checkWord("len15", 8'h01, 8, 8'hE0, 1'b0, 8'h00, 4'd0);
    checkOutput("len15_idle0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] reset during word 0xF0");
    applyStimulus(1'b1, 8'hF0, 4'd8);
    inValid = 1'b0;
    checkOutput("wF0[0]", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wF0[1]", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wF0[2]", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midreset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 4'd8);
    checkWord("w3C", 8'h3C, 8, 8'h40, 1'b0, 8'h00, 4'd0);
    checkOutput("w3C_idle0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w3C_idle1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("w3C_idle2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
